// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters (ALU, LSU, CSR, ...) and the register
// file write-port arbiter, including the registered register file write port.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 3
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          rf_wen;
  logic [ADDR_WIDTH-1:0]         rf_waddr;
  logic [DATA_WIDTH-1:0]         rf_wdata;
  logic                          init_done;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_wen, rf_waddr, rf_wdata, init_done
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_wen, rf_waddr, rf_wdata, init_done
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port owner: zero-sweeps x1..xN-1 after reset, then
// round-robin arbitrates writeback requests onto one registered write port.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave wb
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH:0]   r_init_cnt;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_init_done;

  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_gnt_any;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic [PTR_W-1:0]      w_ptr_nxt;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_wr_live;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum -= NUM_REQ;
    return PTR_W'(sum);
  endfunction

  // Grant only looks at req_valid, so ready never depends on addr/data.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments with every output
    // defaulted first, so no path leaves a signal unassigned (no latch).
    w_grant   = '0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    if (r_state == ST_RUN) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!w_gnt_any && wb.req_valid[wrap_add(r_rr_ptr, k)]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = wrap_add(r_rr_ptr, k);
        end
      end
      if (w_gnt_any) w_grant[w_gnt_idx] = 1'b1;
    end
  end

  assign w_ptr_nxt  = wrap_add(w_gnt_idx, 1);
  assign w_sel_addr = wb.req_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_data = wb.req_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  // x0 writes are consumed but never reach the register file.
  assign w_wr_live  = w_gnt_any && (w_sel_addr != '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_init_cnt == LAST_ADDR) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here, including the output stage, is reset so a
    // mid-operation reset discards any in-flight write immediately.
    if (!rst_n) begin
      r_init_cnt  <= (ADDR_WIDTH+1)'(1);
      r_rr_ptr    <= '0;
      r_wen       <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_init_done <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      case (r_state)
        ST_INIT: begin
          r_wen   <= 1'b1;
          r_waddr <= r_init_cnt[ADDR_WIDTH-1:0];
          r_wdata <= '0;
          if (r_init_cnt == LAST_ADDR) r_init_done <= 1'b1;
          else                         r_init_cnt  <= r_init_cnt + 1'b1;
        end
        default: begin
          r_wen   <= w_wr_live;
          r_waddr <= w_wr_live ? w_sel_addr : '0;
          r_wdata <= w_wr_live ? w_sel_data : '0;
          if (w_gnt_any) r_rr_ptr <= w_ptr_nxt;
        end
      endcase
    end
  end

  assign wb.req_ready = w_grant;
  assign wb.rf_wen    = r_wen;
  assign wb.rf_waddr  = r_waddr;
  assign wb.rf_wdata  = r_wdata;
  assign wb.init_done = r_init_done;
endmodule
